// File: rtl/tile_bank_ring.sv
// Ring of tile RAM banks shared by a renderer (fills one bank at a time) and a
// writer (drains filled banks in commit order). Ownership moves free -> render -> ready -> drain -> free.
module tile_bank_ring #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16
) (
  input  logic                         gpu_clk,
  input  logic                         gpu_resetn,
  input  logic                         r_alloc,
  output logic                         r_grant,
  output logic                         r_busy,
  input  logic                         r_wren,
  input  logic [ADDR_W-1:0]            r_addr,
  input  logic [DATA_W-1:0]            r_data,
  input  logic                         r_commit,
  input  logic                         w_start,
  output logic                         w_grant,
  output logic                         w_busy,
  input  logic [ADDR_W-1:0]            w_addr,
  output logic [DATA_W-1:0]            w_data,
  input  logic                         w_release,
  output logic [$clog2(NUM_BANKS):0]   free_count,
  output logic [$clog2(NUM_BANKS):0]   ready_count,
  output logic                         err
);

  localparam int BW    = $clog2(NUM_BANKS);
  localparam int CW    = BW + 1;
  localparam int DEPTH = NUM_BANKS << ADDR_W;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BANK_ONE = BW'(1);

  typedef enum logic { R_IDLE, R_OWN } r_state_t;
  typedef enum logic { W_IDLE, W_OWN } w_state_t;

  r_state_t r_state, r_state_next;
  w_state_t w_state, w_state_next;

  logic [BW-1:0] alloc_ptr, drain_ptr;
  logic [BW-1:0] r_bank, w_bank;

  logic r_wr_ok, r_commit_ok, w_release_ok, proto_err;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    r_state_next = r_state;
    r_grant      = 1'b0;
    r_wr_ok      = 1'b0;
    r_commit_ok  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_alloc && (free_count != '0)) begin
          r_grant      = 1'b1;
          r_state_next = R_OWN;
        end
      end
      R_OWN: begin
        r_wr_ok = r_wren;
        if (r_commit) begin
          r_commit_ok  = 1'b1;
          r_state_next = R_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    w_state_next = w_state;
    w_grant      = 1'b0;
    w_release_ok = 1'b0;
    case (w_state)
      W_IDLE: begin
        // ready_count is registered, so a bank committed this cycle cannot be granted until next cycle.
        if (w_start && (ready_count != '0)) begin
          w_grant      = 1'b1;
          w_state_next = W_OWN;
        end
      end
      W_OWN: begin
        if (w_release) begin
          w_release_ok = 1'b1;
          w_state_next = W_IDLE;
        end
      end
    endcase
  end

  assign r_busy    = (r_state == R_OWN);
  assign w_busy    = (w_state == W_OWN);
  assign proto_err = (!r_busy && (r_wren || r_commit)) || (!w_busy && w_release);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge gpu_clk or negedge gpu_resetn) begin
    if (!gpu_resetn) begin
      r_state     <= R_IDLE;
      w_state     <= W_IDLE;
      alloc_ptr   <= '0;
      drain_ptr   <= '0;
      r_bank      <= '0;
      w_bank      <= '0;
      free_count  <= CW'(NUM_BANKS);
      ready_count <= '0;
      err         <= 1'b0;
      w_data      <= '0;
    end else begin
      r_state <= r_state_next;
      w_state <= w_state_next;

      if (r_grant) begin
        r_bank    <= alloc_ptr;
        alloc_ptr <= alloc_ptr + BANK_ONE;
      end
      if (w_grant) begin
        w_bank    <= drain_ptr;
        drain_ptr <= drain_ptr + BANK_ONE;
      end

      case ({r_grant, w_release_ok})
        2'b10:   free_count <= free_count - CNT_ONE;
        2'b01:   free_count <= free_count + CNT_ONE;
        default: free_count <= free_count;
      endcase

      case ({r_commit_ok, w_grant})
        2'b10:   ready_count <= ready_count + CNT_ONE;
        2'b01:   ready_count <= ready_count - CNT_ONE;
        default: ready_count <= ready_count;
      endcase

      if (proto_err) err <= 1'b1;

      if (w_busy) w_data <= mem[{w_bank, w_addr}];
    end
  end

  // NOTE: the bank RAM has no reset; clearing it would need a per-word reset
  // path and the contents are meaningless until a renderer fills them.
  always_ff @(posedge gpu_clk) begin
    if (r_wr_ok) mem[{r_bank, r_addr}] <= r_data;
  end

endmodule

// File: tb/tb_tile_bank_ring.sv
// Self-checking bench for tile_bank_ring: directed scenarios plus a random run,
// all compared against a queue-based model of bank ownership and RAM contents.
module tb_tile_bank_ring;

  localparam int NB = 4;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int CW = $clog2(NB) + 1;

  logic          gpu_clk = 1'b0;
  logic          gpu_resetn;
  logic          r_alloc, r_wren, r_commit, w_start, w_release;
  logic [AW-1:0] r_addr, w_addr;
  logic [DW-1:0] r_data;
  logic          r_grant, r_busy, w_grant, w_busy, err;
  logic [DW-1:0] w_data;
  logic [CW-1:0] free_count, ready_count;

  tile_bank_ring #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .gpu_clk     (gpu_clk),
    .gpu_resetn  (gpu_resetn),
    .r_alloc     (r_alloc),
    .r_grant     (r_grant),
    .r_busy      (r_busy),
    .r_wren      (r_wren),
    .r_addr      (r_addr),
    .r_data      (r_data),
    .r_commit    (r_commit),
    .w_start     (w_start),
    .w_grant     (w_grant),
    .w_busy      (w_busy),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_release   (w_release),
    .free_count  (free_count),
    .ready_count (ready_count),
    .err         (err)
  );

  always #5 gpu_clk = ~gpu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: banks handed out round-robin, committed banks queued in order.
  logic [DW-1:0] m_mem [NB][1<<AW];
  bit            m_vld [NB][1<<AW];
  int            ready_q [$];
  bit            m_r_own, m_w_own, m_err;
  int            m_r_bank, m_w_bank, m_next;
  logic [DW-1:0] m_wdata;
  bit            m_wd_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_free();
    return NB - ready_q.size() - int'(m_r_own) - int'(m_w_own);
  endfunction

  function automatic bit exp_rg();
    return r_alloc && !m_r_own && (m_free() > 0);
  endfunction

  function automatic bit exp_wg();
    return w_start && !m_w_own && (ready_q.size() > 0);
  endfunction

  task automatic model_reset();
    m_r_own    = 1'b0;
    m_w_own    = 1'b0;
    m_err      = 1'b0;
    m_next     = 0;
    m_r_bank   = 0;
    m_w_bank   = 0;
    m_wdata    = '0;
    m_wd_known = 1'b1;
    ready_q.delete();
  endtask

  task automatic model_edge();
    bit rg, wg;
    rg = exp_rg();
    wg = exp_wg();
    if (((r_wren || r_commit) && !m_r_own) || (w_release && !m_w_own)) m_err = 1'b1;
    if (m_w_own) begin
      m_wd_known = m_vld[m_w_bank][w_addr];
      m_wdata    = m_mem[m_w_bank][w_addr];
    end
    if (m_r_own && r_wren) begin
      m_mem[m_r_bank][r_addr] = r_data;
      m_vld[m_r_bank][r_addr] = 1'b1;
    end
    if (m_r_own && r_commit) begin
      ready_q.push_back(m_r_bank);
      m_r_own = 1'b0;
    end
    if (m_w_own && w_release) m_w_own = 1'b0;
    if (rg) begin
      m_r_own  = 1'b1;
      m_r_bank = m_next;
      m_next   = (m_next + 1) % NB;
    end
    if (wg) begin
      m_w_own  = 1'b1;
      m_w_bank = ready_q.pop_front();
    end
  endtask

  task automatic check_outputs();
    check("r_grant",     32'(r_grant),     32'(exp_rg()));
    check("w_grant",     32'(w_grant),     32'(exp_wg()));
    check("r_busy",      32'(r_busy),      32'(m_r_own));
    check("w_busy",      32'(w_busy),      32'(m_w_own));
    check("free_count",  32'(free_count),  32'(m_free()));
    check("ready_count", 32'(ready_count), 32'(ready_q.size()));
    check("err",         32'(err),         32'(m_err));
    check("invariant", 32'(int'(free_count) + int'(ready_count) + int'(r_busy) + int'(w_busy)), 32'(NB));
    if (m_wd_known) check("w_data", 32'(w_data), 32'(m_wdata));
  endtask

  task automatic idle_inputs();
    r_alloc   = 1'b0;
    r_wren    = 1'b0;
    r_commit  = 1'b0;
    w_start   = 1'b0;
    w_release = 1'b0;
    r_addr    = '0;
    r_data    = '0;
    w_addr    = '0;
  endtask

  // Inputs are driven just after a rising edge; outputs checked on the falling edge.
  task automatic step();
    @(negedge gpu_clk);
    check_outputs();
    @(posedge gpu_clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    gpu_resetn = 1'b0;
    #2;
    model_reset();
    check("rst free_count",  32'(free_count),  32'(NB));
    check("rst ready_count", 32'(ready_count), 32'd0);
    check("rst err",         32'(err),         32'd0);
    gpu_resetn = 1'b1;
    @(posedge gpu_clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] fill [NB];
    int            free_before;

    idle_inputs();
    model_reset();
    gpu_resetn = 1'b0;
    #12;
    check("reset r_busy",      32'(r_busy),      32'd0);
    check("reset w_busy",      32'(w_busy),      32'd0);
    check("reset free_count",  32'(free_count),  32'(NB));
    check("reset ready_count", 32'(ready_count), 32'd0);
    check("reset err",         32'(err),         32'd0);
    check("reset w_data",      32'(w_data),      32'd0);
    gpu_resetn = 1'b1;
    @(posedge gpu_clk);
    #1;

    // Basic fill / commit / drain of one bank.
    r_alloc = 1'b1;
    #1 check("basic r_grant", 32'(r_grant), 32'd1);
    step();
    check("basic free_count", 32'(free_count), 32'd3);
    idle_inputs();
    r_wren = 1'b1; r_addr = 10'd5; r_data = 16'hABCD; r_commit = 1'b1;
    step();
    idle_inputs();
    check("basic ready_count", 32'(ready_count), 32'd1);
    w_start = 1'b1;
    #1 check("basic w_grant", 32'(w_grant), 32'd1);
    step();
    idle_inputs();
    w_addr = 10'd5;
    step();
    check("basic w_data", 32'(w_data), 32'hABCD);
    w_release = 1'b1;
    step();
    idle_inputs();
    step();

    // Fill all banks with no writer, refuse a fifth, then drain in order.
    reset_pulse();
    for (int i = 0; i < NB; i++) begin
      fill[i] = DW'(16'h1000 + i * 16'h0111);
      r_alloc = 1'b1;
      step();
      idle_inputs();
      r_wren = 1'b1; r_addr = 10'd7; r_data = fill[i]; r_commit = 1'b1;
      step();
      idle_inputs();
    end
    check("full free_count",  32'(free_count),  32'd0);
    check("full ready_count", 32'(ready_count), 32'(NB));
    r_alloc = 1'b1;
    #1 check("full r_grant", 32'(r_grant), 32'd0);
    step();
    idle_inputs();
    check("full r_busy", 32'(r_busy), 32'd0);
    for (int i = 0; i < NB; i++) begin
      w_start = 1'b1;
      step();
      idle_inputs();
      w_addr = 10'd7;
      step();
      check($sformatf("drain%0d w_data", i), 32'(w_data), 32'(fill[i]));
      w_release = 1'b1;
      step();
      idle_inputs();
    end

    // Commit and writer request in the same cycle: no bypass.
    reset_pulse();
    r_alloc = 1'b1;
    step();
    idle_inputs();
    r_commit = 1'b1; w_start = 1'b1;
    #1 check("nobypass w_grant0", 32'(w_grant), 32'd0);
    step();
    r_commit = 1'b0;
    #1 check("nobypass w_grant1", 32'(w_grant), 32'd1);
    step();
    idle_inputs();

    // Renderer grant and writer release together: free_count net zero.
    free_before = int'(free_count);
    r_alloc = 1'b1; w_release = 1'b1;
    step();
    idle_inputs();
    check("net0 free_count", 32'(free_count), 32'(free_before));
    r_commit = 1'b1;
    step();
    idle_inputs();

    // Random protocol-legal traffic.
    for (int i = 0; i < 400; i++) begin
      r_alloc   = 1'($urandom_range(0, 1));
      w_start   = 1'($urandom_range(0, 1));
      r_wren    = m_r_own && ($urandom_range(0, 3) != 0);
      r_commit  = m_r_own && ($urandom_range(0, 5) == 0);
      w_release = m_w_own && ($urandom_range(0, 5) == 0);
      r_addr    = AW'($urandom_range(0, 7));
      r_data    = DW'($urandom);
      w_addr    = AW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();

    // Illegal write in R_IDLE: sticky err, RAM untouched.
    reset_pulse();
    r_alloc = 1'b1;
    step();
    idle_inputs();
    r_wren = 1'b1; r_addr = 10'd9; r_data = 16'h1234; r_commit = 1'b1;
    step();
    idle_inputs();
    r_wren = 1'b1; r_addr = 10'd9; r_data = 16'hDEAD;
    step();
    idle_inputs();
    check("illegal err", 32'(err), 32'd1);
    w_start = 1'b1;
    step();
    idle_inputs();
    w_addr = 10'd9;
    step();
    check("illegal ram", 32'(w_data), 32'h1234);
    w_release = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    check("illegal err sticky", 32'(err), 32'd1);
    reset_pulse();
    check("illegal err cleared", 32'(err), 32'd0);

    // Asynchronous reset while both sides own a bank.
    r_alloc = 1'b1;
    step();
    idle_inputs();
    r_commit = 1'b1;
    step();
    idle_inputs();
    r_alloc = 1'b1; w_start = 1'b1;
    step();
    idle_inputs();
    check("async pre r_busy", 32'(r_busy), 32'd1);
    check("async pre w_busy", 32'(w_busy), 32'd1);
    #1;
    gpu_resetn = 1'b0;
    #1;
    model_reset();
    check("async free_count",  32'(free_count),  32'(NB));
    check("async ready_count", 32'(ready_count), 32'd0);
    check("async r_busy",      32'(r_busy),      32'd0);
    check("async w_busy",      32'(w_busy),      32'd0);
    gpu_resetn = 1'b1;
    @(posedge gpu_clk);
    #1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_bank_ring.md
TILE_BANK_RING -- requirements
Module: tile_bank_ring

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, meaning the number of tile RAM banks (power of 2, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 10, meaning the per-bank pixel address width (2^ADDR_W words per bank).
REQ-003 SHALL have parameter DATA_W, default 16, meaning the pixel width.
REQ-004 SHALL have port gpu_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port gpu_resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port r_alloc  input  1  renderer requests a free bank.
REQ-007 SHALL have port r_grant  output  1  renderer request accepted this cycle.
REQ-008 SHALL have port r_busy  output  1  renderer currently owns a bank.
REQ-009 SHALL have ports r_wren  input  1, r_addr  input  ADDR_W, r_data  input  DATA_W: pixel write into the owned bank.
REQ-010 SHALL have port r_commit  input  1  renderer finished; owned bank becomes ready.
REQ-011 SHALL have port w_start  input  1  writer requests the oldest ready bank.
REQ-012 SHALL have port w_grant  output  1  writer request accepted this cycle.
REQ-013 SHALL have port w_busy  output  1  writer currently owns a bank.
REQ-014 SHALL have ports w_addr  input  ADDR_W, w_data  output  DATA_W: pixel read from the drained bank.
REQ-015 SHALL have port w_release  input  1  writer finished; drained bank becomes free.
REQ-016 SHALL have ports free_count and ready_count, each output  $clog2(NUM_BANKS)+1: bank counts.
REQ-017 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-018 SHALL hold NUM_BANKS internal banks of 2^ADDR_W x DATA_W, one write port (renderer) and one read port (writer).
REQ-019 SHALL use a renderer FSM R_IDLE->R_OWN on r_grant and R_OWN->R_IDLE on r_commit; r_busy = (state==R_OWN).
REQ-020 SHALL use a writer FSM W_IDLE->W_OWN on w_grant and W_OWN->W_IDLE on w_release; w_busy = (state==W_OWN).
REQ-021 SHALL drive r_grant combinationally = r_alloc & R_IDLE & (free_count!=0).
REQ-022 SHALL drive w_grant combinationally = w_start & W_IDLE & (ready_count!=0).
REQ-023 SHALL allocate banks in ring order via alloc_ptr, incremented modulo NUM_BANKS on r_grant; the bank index owned is the pre-increment value.
REQ-024 SHALL drain banks in ring order via drain_ptr, incremented modulo NUM_BANKS on w_grant, so banks drain in commit order.
REQ-025 SHALL accept r_wren writes only in R_OWN, to the owned bank; writes in the grant cycle itself SHALL be ignored.
REQ-026 SHALL register w_data with 1-cycle latency from w_addr, updating only in W_OWN (including the release cycle); w_data otherwise holds.
REQ-027 SHALL update free_count by -1 on r_grant and +1 on accepted w_release; both in one cycle gives net 0.
REQ-028 SHALL update ready_count by +1 on accepted r_commit and -1 on w_grant; both in one cycle gives net 0.
REQ-029 SHALL have no bypass: a bank committed in cycle N SHALL be grantable to the writer no earlier than cycle N+1.
REQ-030 SHALL maintain the invariant free_count + ready_count + r_busy + w_busy == NUM_BANKS at all times.
REQ-031 SHALL, for r_alloc with free_count==0 or w_start with ready_count==0, produce no grant and no state change; the requester retries.
REQ-032 SHALL set err on r_wren or r_commit in R_IDLE, or w_release in W_IDLE; such inputs SHALL otherwise have no effect.
REQ-033 SHALL clear err only by reset.

Reset
REQ-034 SHALL, on gpu_resetn low (asynchronous), force R_IDLE, W_IDLE, alloc_ptr=0, drain_ptr=0, free_count=NUM_BANKS, ready_count=0, err=0, w_data=0.
REQ-035 SHALL not reset bank RAM contents; reset mid-operation SHALL discard all ownership and queued banks.

Verification
REQ-036 SHALL verify: reset, then r_alloc -> r_grant=1 same cycle, free_count 4->3; writes {addr 5 = 0xABCD} plus r_commit -> ready_count=1; w_start -> w_grant; w_addr=5 -> w_data=0xABCD next cycle.
REQ-037 SHALL verify: four alloc/commit cycles with distinct fill values, no writer -> free_count=0, 5th r_alloc gets r_grant=0; writer then drains in banks 0,1,2,3 order with matching data.
REQ-038 SHALL verify: r_commit and w_start in the same cycle with ready_count=0 -> w_grant=0 that cycle, w_grant=1 the next cycle.
REQ-039 SHALL verify: r_grant and w_release in the same cycle -> free_count unchanged; invariant holds every cycle of a random alloc/commit/start/release run.
REQ-040 SHALL verify: r_wren in R_IDLE -> err=1, RAM unchanged, err stays 1 until gpu_resetn pulse.
REQ-041 SHALL verify: gpu_resetn asserted while both sides busy -> counts return to 4/0 and busy flags drop without waiting for gpu_clk.
